// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: state encoding, port IDs, default widths.
package data_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    BURST1 = 2'd2
  } arb_state_e;

  localparam logic PORT_CPU  = 1'b0;
  localparam logic PORT_LOAD = 1'b1;

  localparam int unsigned DEF_ADDR_W = 11;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_BE_W   = 4;
  localparam int unsigned DEF_LEN_W  = 4;

endpackage

// File: rtl/data_mem_arbiter_beat_counter.sv
// Remaining-beat counter for loader bursts: load, saturating decrement, zero flag.
module arb_beat_counter #(
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [LEN_W-1:0] loadVal,
  input  logic             dec,
  output logic             zero
);

  logic [LEN_W-1:0] cntQ, cntD;

  // Next count: load wins over decrement; never wraps below zero.
  always_comb begin
    cntD = cntQ;
    if (load) begin
      cntD = loadVal;
    end else if (dec && (cntQ != '0)) begin
      cntD = cntQ - LEN_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cntQ <= '0;
    end else begin
      cntQ <= cntD;
    end
  end

  assign zero = (cntQ == '0);

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port data-memory arbiter: single-beat CPU port, bursting loader port,
// alternating priority on conflict, one-cycle read-valid pipeline.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned BE_W   = DEF_BE_W,
  parameter int unsigned LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [BE_W-1:0]   we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic              stall0,
  input  logic              req1,
  input  logic [BE_W-1:0]   we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [LEN_W-1:0]  len1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic              mem_en,
  output logic [BE_W-1:0]   mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rdata
);

  arb_state_e stateQ, stateD;
  logic       lastQ, lastD;
  logic       rvalid0Q, rvalid1Q;
  logic       gnt0Raw, gnt1Raw;
  logic       cntLoad, cntDec, cntZero;
  logic       winner;

  // The grant that starts a burst is its first beat, so the counter holds the
  // beats still owed after it; len1 == 0 never enters BURST1.
  arb_beat_counter #(
    .LEN_W(LEN_W)
  ) u_beat_counter (
    .clk    (clk),
    .reset  (reset),
    .load   (cntLoad),
    .loadVal(len1 - LEN_W'(1)),
    .dec    (cntDec),
    .zero   (cntZero)
  );

  // Arbitration and next state; grants are issued in the cycle of the request.
  always_comb begin
    stateD  = stateQ;
    lastD   = lastQ;
    gnt0Raw = 1'b0;
    gnt1Raw = 1'b0;
    cntLoad = 1'b0;
    cntDec  = 1'b0;
    winner  = PORT_CPU;
    case (stateQ)
      IDLE, GRANT0: begin
        if (req0 && req1) begin
          winner = (lastQ == PORT_CPU) ? PORT_LOAD : PORT_CPU;
        end else begin
          winner = req1 ? PORT_LOAD : PORT_CPU;
        end
        if (req0 || req1) begin
          if (winner == PORT_CPU) begin
            gnt0Raw = 1'b1;
            lastD   = PORT_CPU;
            stateD  = GRANT0;
          end else begin
            gnt1Raw = 1'b1;
            lastD   = PORT_LOAD;
            if (len1 != '0) begin
              cntLoad = 1'b1;
              stateD  = BURST1;
            end else begin
              stateD = IDLE;
            end
          end
        end else begin
          stateD = IDLE;
        end
      end
      BURST1: begin
        // A dropped req1 aborts the burst without touching memory.
        if (req1) begin
          gnt1Raw = 1'b1;
          if (cntZero) begin
            stateD = IDLE;
          end else begin
            cntDec = 1'b1;
          end
        end else begin
          stateD = IDLE;
        end
      end
      default: stateD = IDLE;
    endcase
  end

  // State and last-winner registers; last resets to the loader so the CPU wins first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ <= IDLE;
      lastQ  <= PORT_LOAD;
    end else begin
      stateQ <= stateD;
      lastQ  <= lastD;
    end
  end

  // Reset blanks grants immediately, even before the next clock edge.
  assign gnt0   = gnt0Raw & reset;
  assign gnt1   = gnt1Raw & reset;
  assign stall0 = req0 & ~gnt0;

  // Shared memory port mux; idle drives all zeros.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt0) begin
      mem_en    = 1'b1;
      mem_we    = we0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (gnt1) begin
      mem_en    = 1'b1;
      mem_we    = we1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end
  end

  // Read-valid pipeline: flags a granted read beat one cycle later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rvalid0Q <= 1'b0;
      rvalid1Q <= 1'b0;
    end else begin
      rvalid0Q <= gnt0 && (we0 == '0);
      rvalid1Q <= gnt1 && (we1 == '0);
    end
  end

  assign rvalid0 = rvalid0Q;
  assign rvalid1 = rvalid1Q;
  assign rdata   = mem_rdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: directed scenarios then randomized traffic,
// checked against a beat-counting reference model.
module tb_data_mem_arbiter;

  localparam int unsigned AW = 11;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;
  localparam int unsigned LW = 4;
  localparam int unsigned VW = 4 + BW + AW + DW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [BW-1:0] we0 = '0, we1 = '0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic [LW-1:0] len1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, stall0, mem_en;
  logic [BW-1:0] mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, rdata;
  logic [DW-1:0] mem_rdata = '0;

  data_mem_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .BE_W  (BW),
    .LEN_W (LW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req0     (req0),
    .we0      (we0),
    .addr0    (addr0),
    .wdata0   (wdata0),
    .gnt0     (gnt0),
    .rvalid0  (rvalid0),
    .stall0   (stall0),
    .req1     (req1),
    .we1      (we1),
    .addr1    (addr1),
    .wdata1   (wdata1),
    .len1     (len1),
    .gnt1     (gnt1),
    .rvalid1  (rvalid1),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .rdata    (rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rd_hash(input logic [AW-1:0] a);
    return 32'h5A5A_1234 ^ {a, 10'h000, a};
  endfunction

  // Memory device: read data one cycle after a read access, junk otherwise.
  always @(posedge clk) begin
    mem_rdata <= (mem_en && mem_we == '0) ? rd_hash(mem_addr) : $urandom;
  end

  typedef struct {
    int            cyc;
    logic [VW-1:0] vec;
  } exp_t;

  typedef struct {
    int            cyc;
    bit            port;
    logic [DW-1:0] data;
  } rd_t;

  exp_t expQ[$];
  rd_t  rdQ[$];
  int   nChecks = 0;
  int   nPass = 0;
  int   cyc = 0;

  // Reference model state: beats still owed to the loader, and who won last.
  int   mRemain = 0;
  bit   mLast = 1'b1;
  bit   mG0, mG1;

  task automatic cyc_begin(input logic rst);
    @(posedge clk);
    #1;
    cyc++;
    reset = rst;
  endtask

  // Evaluate the model for the inputs just driven and queue the expected outputs.
  task automatic eval();
    logic g0, g1;
    logic [BW-1:0] we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    exp_t e;
    rd_t  r;
    g0 = 1'b0;
    g1 = 1'b0;
    we = '0;
    a  = '0;
    d  = '0;
    if (!reset) begin
      mRemain = 0;
      mLast   = 1'b1;
      rdQ.delete();
    end else if (mRemain > 0) begin
      if (req1) begin
        g1 = 1'b1;
        mRemain--;
      end else begin
        mRemain = 0;
      end
    end else begin
      g0 = req0 && (!req1 || mLast);
      g1 = req1 && !g0;
      if (g0) mLast = 1'b0;
      if (g1) begin
        mLast   = 1'b1;
        mRemain = int'(len1);
      end
    end
    if (g0) begin
      we = we0;
      a  = addr0;
      d  = wdata0;
    end
    if (g1) begin
      we = we1;
      a  = addr1;
      d  = wdata1;
    end
    if ((g0 || g1) && we == '0) begin
      r.cyc  = cyc + 1;
      r.port = g1;
      r.data = rd_hash(a);
      rdQ.push_back(r);
    end
    mG0 = g0;
    mG1 = g1;
    e.cyc = cyc;
    e.vec = {g0, g1, (req0 && !g0), (g0 || g1), we, a, d};
    expQ.push_back(e);
  endtask

  // Monitor: compares every cycle's outputs and every presented read response.
  initial begin
    exp_t e;
    rd_t  r;
    logic [VW-1:0] act;
    forever begin
      @(negedge clk);
      act = {gnt0, gnt1, stall0, mem_en, mem_we, mem_addr, mem_wdata};
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        nChecks++;
        if (e.cyc != cyc || act !== e.vec) begin
          $display("FAIL outputs cyc %0d (exp cyc %0d): got %h want %h [gnt0 gnt1 stall0 en we addr wdata]",
                   cyc, e.cyc, act, e.vec);
        end else begin
          nPass++;
        end
      end
      while (rdQ.size() > 0 && rdQ[0].cyc < cyc) begin
        r = rdQ.pop_front();
        nChecks++;
        $display("FAIL missing_rvalid cyc %0d: got rvalid0=0 rvalid1=0 want rvalid%0d=1", r.cyc, r.port);
      end
      if (rvalid0 || rvalid1) begin
        nChecks++;
        if (rdQ.size() == 0 || rdQ[0].cyc != cyc) begin
          $display("FAIL unexpected_rvalid cyc %0d: got rvalid0=%b rvalid1=%b want none", cyc, rvalid0,
                   rvalid1);
        end else begin
          r = rdQ.pop_front();
          if ((rvalid0 && rvalid1) || rvalid1 !== r.port || rdata !== r.data) begin
            $display("FAIL read_resp cyc %0d: got rv0=%b rv1=%b rdata=%h want port%0d rdata=%h", cyc,
                     rvalid0, rvalid1, rdata, r.port, r.data);
          end else begin
            nPass++;
          end
        end
      end
    end
  end

  // Loader burst: req1 held for len+1 beats unless dropped or cut by reset;
  // optional CPU request raised at a given cycle and held until granted.
  task automatic burst(input logic [LW-1:0] len, input logic [BW-1:0] be, input int dropAt,
                       input int req0At, input int rstAt);
    bit pend = 1'b0;
    for (int i = 0; i < int'(len) + 20; i++) begin
      cyc_begin((i == rstAt) ? 1'b0 : 1'b1);
      req1   = (i <= int'(len)) && (i < dropAt) && (rstAt < 0 || i <= rstAt);
      we1    = be;
      addr1  = AW'(32'h100 + i);
      wdata1 = $urandom;
      len1   = (i == 0) ? len : LW'($urandom);
      if (i == req0At) pend = 1'b1;
      req0   = pend;
      we0    = '0;
      addr0  = 11'h055;
      wdata0 = $urandom;
      eval();
      if (mG0) pend = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit p0Pend = 1'b0;
    bit p1Pend = 1'b0;

    // Reset held for a few cycles: everything idle.
    for (int i = 0; i < 3; i++) begin
      cyc_begin(1'b0);
      eval();
    end

    // Conflicts right after reset: CPU first, then alternation.
    cyc_begin(1'b1);
    req0 = 1'b1; req1 = 1'b1; len1 = '0;
    we0 = '0; we1 = '0; addr0 = 11'h020; addr1 = 11'h040;
    wdata0 = $urandom; wdata1 = $urandom;
    eval();
    cyc_begin(1'b1);
    req0 = 1'b0;
    eval();
    cyc_begin(1'b1);
    req0 = 1'b1; addr0 = 11'h021; addr1 = 11'h041;
    eval();
    cyc_begin(1'b1);
    eval();
    cyc_begin(1'b1);
    eval();
    cyc_begin(1'b1);
    req0 = 1'b0; req1 = 1'b0;
    eval();

    // CPU-only read of 0x010.
    cyc_begin(1'b1);
    req0 = 1'b1; we0 = '0; addr0 = 11'h010; wdata0 = $urandom;
    eval();
    cyc_begin(1'b1);
    req0 = 1'b0;
    eval();

    burst(4'd3, 4'hF, 99, 1, -1);   // write burst, CPU stalls behind it
    burst(4'd7, 4'h0, 2, -1, -1);   // aborted after two beats
    burst(4'd3, 4'h0, 99, -1, 1);   // reset during second beat
    burst(4'd0, 4'h0, 99, -1, -1);  // single beat

    // CPU write beat: no read response.
    cyc_begin(1'b1);
    req0 = 1'b1; we0 = 4'h3; addr0 = 11'h033; wdata0 = $urandom;
    eval();
    cyc_begin(1'b1);
    req0 = 1'b0;
    eval();

    burst(4'd15, 4'h0, 99, 0, -1);  // 16 beats while the CPU waits the worst case

    // Randomized traffic with requests held until granted or occasionally withdrawn.
    for (int n = 0; n < 3000; n++) begin
      cyc_begin(($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1);
      if (!p0Pend) begin
        we0    = ($urandom_range(0, 1) == 0) ? '0 : BW'($urandom);
        addr0  = AW'($urandom);
        wdata0 = $urandom;
        if ($urandom_range(0, 3) == 0) begin
          p0Pend = 1'b1;
          req0   = 1'b1;
        end else begin
          req0 = 1'b0;
        end
      end else if ($urandom_range(0, 31) == 0) begin
        p0Pend = 1'b0;
        req0   = 1'b0;
      end
      if (mRemain > 0) begin
        req1   = ($urandom_range(0, 19) != 0);
        we1    = ($urandom_range(0, 1) == 0) ? '0 : BW'($urandom);
        addr1  = AW'($urandom);
        wdata1 = $urandom;
        len1   = LW'($urandom);
      end else if (p1Pend) begin
        if ($urandom_range(0, 31) == 0) begin
          p1Pend = 1'b0;
          req1   = 1'b0;
        end
      end else if ($urandom_range(0, 4) == 0) begin
        p1Pend = 1'b1;
        req1   = 1'b1;
        we1    = ($urandom_range(0, 1) == 0) ? '0 : BW'($urandom);
        addr1  = AW'($urandom);
        wdata1 = $urandom;
        case ($urandom_range(0, 3))
          0:       len1 = '0;
          1:       len1 = '1;
          default: len1 = LW'($urandom);
        endcase
      end else begin
        req1 = 1'b0;
      end
      eval();
      if (mG0) p0Pend = 1'b0;
      if (mG1) p1Pend = 1'b0;
    end

    // Drain: idle cycles so outstanding read responses are checked.
    for (int i = 0; i < 5; i++) begin
      cyc_begin(1'b1);
      req0 = 1'b0;
      req1 = 1'b0;
      eval();
    end
    @(negedge clk);
    #1;
    nChecks++;
    if (rdQ.size() != 0 || expQ.size() != 0) begin
      $display("FAIL drain: got %0d reads and %0d cycles outstanding want 0 and 0", rdQ.size(),
               expQ.size());
    end else begin
      nPass++;
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 The block SHALL have parameters ADDR_W, default 11, word address width matching the data-memory word index.
REQ-002 The block SHALL have parameters DATA_W, default 32, data width; BE_W, default 4, byte-write-enable width.
REQ-003 The block SHALL have parameter LEN_W, default 4, port-1 burst-length field width (max 16 beats).
REQ-004 The block SHALL use one clock and an asynchronous active-low reset, with ports as follows.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- req0 / we0 / addr0 / wdata0  input  1/BE_W/ADDR_W/DATA_W  CPU port request, byte enables, word address, write data.
- gnt0 / rvalid0 / stall0  output  1/1/1  CPU grant, read-data valid, CPU stall.
- req1 / we1 / addr1 / wdata1 / len1  input  1/BE_W/ADDR_W/DATA_W/LEN_W  loader port; len1 = beats-1, sampled at burst start.
- gnt1 / rvalid1  output  1/1  loader grant, read-data valid.
- mem_en / mem_we / mem_addr / mem_wdata  output  1/BE_W/ADDR_W/DATA_W  shared data-memory port.
- mem_rdata  input  DATA_W  memory read data, valid one cycle after mem_en.
- rdata  output  DATA_W  mem_rdata passthrough, qualified by rvalid0/rvalid1.

Function
REQ-005 The FSM SHALL have states IDLE, GRANT0, and BURST1, plus a registered last-winner bit `last`.
REQ-006 Arbitration SHALL be evaluated combinationally each cycle; a grant is issued in the same cycle as the request it serves.
REQ-007 When only one port requests, the block SHALL grant that port.
REQ-008 When both ports request, the block SHALL grant the port other than `last`.
REQ-009 A port-0 grant SHALL last one beat: gnt0=1, mem_en=1, and mem_we/addr/wdata driven from port 0; `last` SHALL then become 0.
REQ-010 A port-1 grant SHALL capture len1 into beat counter cnt, assert gnt1, enter BURST1, and set `last` to 1.
REQ-011 In BURST1, every cycle with req1=1 SHALL be one beat: gnt1=1, memory driven from port 1, and cnt decremented.
REQ-012 A burst SHALL end on the beat where cnt=0, or the first cycle req1=0 (abort, no memory access); the FSM SHALL then return to IDLE.
REQ-013 While in BURST1, port 0 SHALL NOT be granted; on burst end, a pending req0 SHALL win the next cycle.
REQ-014 stall0 SHALL equal req0 & ~gnt0, combinationally.
REQ-015 rvalidN SHALL be asserted exactly one cycle after a granted beat from port N with weN=0, and SHALL be 0 for writes.
REQ-016 When no grant is issued, the block SHALL drive mem_en=0, mem_we=0, gnt0=gnt1=0, and SHALL hold mem_addr/mem_wdata at 0.
REQ-017 A len1=0 burst SHALL be a single beat; len1=15 SHALL produce 16 beats; cnt SHALL NOT wrap.
REQ-018 The worst-case port-0 wait SHALL be 16 cycles.
REQ-019 A request SHALL be held by its requester until granted; a dropped request SHALL be treated as withdrawn with no side effect.

Reset
REQ-020 Asserting reset SHALL immediately force state=IDLE, cnt=0, `last`=1 (so port 0 wins the first conflict), rvalid0=rvalid1=0, and all grant and memory outputs to 0.
REQ-021 Reset asserted mid-burst SHALL abandon the burst; no rvalid SHALL follow a beat cut by reset.
REQ-022 Reset deassertion SHALL take effect at a clock edge; the first grant SHALL be possible in the first cycle after release.

Structure
REQ-023 A shared package SHALL hold the state encoding (IDLE/GRANT0/BURST1), port-ID constants (PORT_CPU=0, PORT_LOAD=1), and default widths.
REQ-024 One sub-module, arb_beat_counter, SHALL be used (load/decrement/zero flag); the FSM, mux, and rvalid pipeline SHALL stay in data_mem_arbiter.

Verification
REQ-025 CPU-only: req0=1, we0=0, addr0=0x010 -> gnt0=1 and mem_addr=0x010 in the same cycle; next cycle rvalid0=1 and rdata=mem_rdata.
REQ-026 Conflict after reset: req0=req1=1 -> port 0 is granted first, port 1 the next cycle; a repeated conflict after that alternates.
REQ-027 Burst: len1=3, req1 held, we1=0xF -> 4 beats with gnt1=1 and mem_we=0xF; req0 raised at beat 1 -> stall0=1 for 3 cycles, then gnt0=1 on the cycle after beat 4.
REQ-028 Abort: len1=7, req1 dropped after 2 beats -> FSM returns to IDLE, mem_en=0 that cycle, and no further gnt1.
REQ-029 Reset mid-burst: reset=0 during beat 2 of a read burst -> all outputs are 0 immediately, with no rvalid1 the next cycle.
REQ-030 Boundaries: len1=0 gives 1 beat; len1=15 gives exactly 16 beats; a write beat (we0=0x3) gives no rvalid0.
